// File: rtl/spi_sd_pkg.sv
// Shared register offsets, status bit positions and transfer state encoding
// for the memory-mapped SPI master.
package spi_sd_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_SS   = 2'd3;

    localparam int BIT_BUSY = 7;
    localparam int BIT_DONE = 6;
    localparam int BIT_OVR  = 5;
    localparam int BIT_IE   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } xfer_state_e;

endpackage

// File: rtl/spi_sd_shift_engine.sv
// Mode-0 MSB-first 8-bit shift engine: half-period divider, sck/mosi
// generation, miso synchronizer and the TX/RX shift registers.
module spi_sd_shift_engine
    import spi_sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [7:0] div,
    input  logic       miso,
    output logic       busy,
    output logic       done_pulse,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);

    xfer_state_e state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [7:0]  tx_sh, tx_sh_nx;
    logic [7:0]  rx_sh, rx_sh_nx;
    logic [3:0]  hcnt, hcnt_nx;
    logic        sck_nx, mosi_nx;
    logic [1:0]  miso_sync;

    assign busy    = (state == ST_SHIFT);
    assign rx_byte = rx_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            hcnt      <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b1;
            miso_sync <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tx_sh     <= tx_sh_nx;
            rx_sh     <= rx_sh_nx;
            hcnt      <= hcnt_nx;
            sck       <= sck_nx;
            mosi      <= mosi_nx;
            miso_sync <= {miso_sync[0], miso};
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        tx_sh_nx   = tx_sh;
        rx_sh_nx   = rx_sh;
        hcnt_nx    = hcnt;
        sck_nx     = sck;
        mosi_nx    = mosi;
        done_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_SHIFT;
                    tx_sh_nx = tx_byte;
                    mosi_nx  = tx_byte[7];
                    sck_nx   = 1'b0;
                    cnt_nx   = div;
                    hcnt_nx  = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else begin
                    cnt_nx  = div;
                    sck_nx  = ~sck;
                    hcnt_nx = hcnt + 4'd1;
                    if (!sck) begin
                        rx_sh_nx = {rx_sh[6:0], miso_sync[1]};
                    end else if (hcnt == 4'd15) begin
                        // sixteenth half-period: byte complete, back to idle
                        done_pulse = 1'b1;
                        state_nx   = ST_IDLE;
                        mosi_nx    = 1'b1;
                    end else begin
                        tx_sh_nx = {tx_sh[6:0], 1'b0};
                        mosi_nx  = tx_sh[6];
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/spi_sd_ctrl.sv
// 6502-bus SPI master for SD cards: register file, bus decode and IRQ.
// Optional interrupt enable under `SPI_SD_CTRL_IRQ_EN.
module spi_sd_ctrl
    import spi_sd_pkg::*;
#(
    parameter int         NUM_SS    = 1,
    parameter logic [7:0] DIV_RESET = 8'd2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [1:0]        rs,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              irq_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_SS-1:0] spi_ss_n
);

    logic [7:0]        rx_q, div_q, rx_byte, ss_rd;
    logic [NUM_SS-1:0] ss_q;
    logic              done_q, done_nx, ovr_q, ie;
    logic              busy, done_pulse, start;
    logic              data_wr, data_rd, stat_wr;

    assign data_wr  = cs && we && (rs == REG_DATA);
    assign data_rd  = cs && !we && (rs == REG_DATA);
    assign stat_wr  = cs && we && (rs == REG_STAT);
    assign start    = data_wr && !busy;
    // completion beats a same-cycle DATA read
    assign done_nx  = done_pulse ? 1'b1 : (data_rd ? 1'b0 : done_q);
    assign spi_ss_n = ss_q;

    spi_sd_shift_engine u_eng (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tx_byte    (data_in),
        .div        (div_q),
        .miso       (spi_miso),
        .busy       (busy),
        .done_pulse (done_pulse),
        .rx_byte    (rx_byte),
        .sck        (spi_sck),
        .mosi       (spi_mosi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q   <= '0;
            div_q  <= DIV_RESET;
            ss_q   <= '1;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= done_nx;
            if (done_pulse)
                rx_q <= rx_byte;
            if (data_wr && busy)
                ovr_q <= 1'b1;
            else if (stat_wr && data_in[BIT_OVR])
                ovr_q <= 1'b0;
            if (cs && we && (rs == REG_DIV) && !busy)
                div_q <= data_in;
            if (cs && we && (rs == REG_SS))
                ss_q <= data_in[NUM_SS-1:0];
        end
    end

`ifdef SPI_SD_CTRL_IRQ_EN
    logic ie_q, ie_nx, irq_q;
    assign ie_nx = stat_wr ? data_in[BIT_IE] : ie_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b1;
        end else begin
            ie_q  <= ie_nx;
            irq_q <= ~(ie_nx & done_nx);
        end
    end
    assign ie    = ie_q;
    assign irq_n = irq_q;
`else
    assign ie    = 1'b0;
    assign irq_n = 1'b1;
`endif

    always_comb begin
        ss_rd             = '0;
        ss_rd[NUM_SS-1:0] = ss_q;
    end

    always_comb begin
        data_out = '0;
        case (rs)
            REG_DATA: data_out = rx_q;
            REG_STAT: begin
                data_out[BIT_BUSY] = busy;
                data_out[BIT_DONE] = done_q;
                data_out[BIT_OVR]  = ovr_q;
                data_out[BIT_IE]   = ie;
            end
            REG_DIV:  data_out = div_q;
            default:  data_out = ss_rd;
        endcase
    end

endmodule

// File: tb/tb_spi_sd_ctrl.sv
// Directed + randomized bench for spi_sd_ctrl; miso is looped from mosi or
// forced low, and the expected RX byte, timing and flags come from a byte-level model.
module tb_spi_sd_ctrl;
    import spi_sd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0, we = 1'b0;
    logic [1:0] rs = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] dout;
    logic       irq_n, spi_sck, spi_mosi, spi_miso;
    logic [0:0] spi_ss_n;
    logic       miso_zero = 1'b0;
    logic       ie_exp = 1'b0;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;
    assign spi_miso = miso_zero ? 1'b0 : spi_mosi;

    spi_sd_ctrl #(.NUM_SS(1), .DIV_RESET(8'd2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .data_in(data_in),
        .data_out(dout), .irq_n(irq_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_ss_n(spi_ss_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; rs = r; data_in = d;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; rs = r;
        #1 d = dout;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    // One full transfer with an optional single bus write injected at poll index inj.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] div, input logic mz,
                            input int inj, input logic [1:0] inj_rs, input logic [7:0] inj_d);
        int idx, last, bad, rises, blen;
        logic [7:0] seen, rx_exp, rd;
        logic psck, busy_s, ovr_exp;
        miso_zero = mz;
        rx_exp  = mz ? 8'h00 : tx;
        ovr_exp = (inj > 0) && (inj_rs == REG_DATA);
        bus_write(REG_DATA, tx);
        cs = 1'b1; we = 1'b0; rs = REG_STAT;
        idx = 0; last = 1; bad = 0; rises = 0; blen = 0; seen = 8'h00; psck = 1'b0; busy_s = 1'b1;
        while (busy_s && idx < 5000) begin
            @(negedge clk);
            idx++;
            busy_s = dout[BIT_BUSY];
            if (busy_s) blen++;
            if (spi_sck !== psck) begin
                if (idx - last != int'(div) + 1) bad++;
                last = idx;
                if (spi_sck) begin
                    seen = {seen[6:0], spi_mosi};
                    rises++;
                end
            end
            psck = spi_sck;
            if (idx == inj + 1 && inj_rs == REG_SS)
                chk("ss_follow", 32'(spi_ss_n), 32'(inj_d[0]));
            if (idx == inj) begin
                we = 1'b1; rs = inj_rs; data_in = inj_d;
                @(posedge clk); #1;
                we = 1'b0; rs = REG_STAT;
            end
        end
        chk("timeout", 32'(idx < 5000), 32'd1);
        chk("busy_len", 32'(blen), 32'(16 * (int'(div) + 1)));
        chk("sck_timing", 32'(bad), 32'd0);
        chk("sck_pulses", 32'(rises), 32'd8);
        chk("mosi_seq", 32'(seen), 32'(tx));
        chk("idle_lines", {30'd0, spi_sck, spi_mosi}, 32'd1);
        chk("stat_done", 32'(dout), 32'(8'h40 | (ovr_exp ? 8'h20 : 8'h00) | 8'(ie_exp)));
        chk("irq_done", 32'(irq_n), 32'(!ie_exp));
        rs = REG_DATA;
        #1 chk("rx_byte", 32'(dout), 32'(rx_exp));
        @(posedge clk); #1;
        rs = REG_STAT;
        #1 chk("stat_after_rd", 32'(dout), 32'((ovr_exp ? 8'h20 : 8'h00) | 8'(ie_exp)));
        cs = 1'b0;
        @(negedge clk);
        chk("irq_clr", 32'(irq_n), 32'd1);
        if (ovr_exp) begin
            bus_write(REG_STAT, 8'h20 | 8'(ie_exp));
            bus_read(REG_STAT, rd);
            chk("ovr_clr", 32'(rd), 32'(ie_exp));
        end
        if (inj > 0 && inj_rs == REG_DIV) begin
            bus_read(REG_DIV, rd);
            chk("div_locked", 32'(rd), 32'(div));
        end
    endtask

    initial begin
        logic [7:0] rd, tx, dv;
        logic mz;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("rst_lines", {29'd0, spi_sck, spi_mosi, spi_ss_n}, 32'd3);
        chk("rst_irq", 32'(irq_n), 32'd1);
        bus_read(REG_STAT, rd); chk("rst_stat", 32'(rd), 32'h00);
        bus_read(REG_DATA, rd); chk("rst_rx", 32'(rd), 32'h00);
        bus_read(REG_DIV, rd);  chk("rst_div", 32'(rd), 32'h02);
        bus_read(REG_SS, rd);   chk("rst_ss", 32'(rd), 32'h01);

        run_xfer(8'hA5, 8'd2, 1'b0, -1, REG_STAT, 8'h00);
        run_xfer(8'hFF, 8'd2, 1'b1, -1, REG_STAT, 8'h00);
        run_xfer(8'h3C, 8'd2, 1'b0, 20, REG_DATA, 8'h11);
        run_xfer(8'h96, 8'd2, 1'b0, 12, REG_SS, 8'h00);
        run_xfer(8'h69, 8'd2, 1'b0, 30, REG_SS, 8'h01);
        run_xfer(8'hC3, 8'd2, 1'b0, 48, REG_DATA, 8'h77);
        run_xfer(8'h5A, 8'd2, 1'b0, 10, REG_DIV, 8'h07);

        bus_write(REG_STAT, 8'h01);
`ifdef SPI_SD_CTRL_IRQ_EN
        ie_exp = 1'b1;
`else
        ie_exp = 1'b0;
`endif
        bus_read(REG_STAT, rd); chk("ie_rd", 32'(rd), 32'(ie_exp));

        for (int i = 0; i < 6; i++) begin
            dv = 8'($urandom_range(2, 5));
            tx = 8'($urandom);
            mz = 1'($urandom_range(0, 1));
            bus_write(REG_DIV, dv);
            bus_read(REG_DIV, rd); chk("div_rw", 32'(rd), 32'(dv));
            run_xfer(tx, dv, mz, -1, REG_STAT, 8'h00);
        end

        bus_write(REG_DIV, 8'd2);
        bus_write(REG_SS, 8'h00);
        bus_write(REG_DATA, 8'h5A);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        ie_exp = 1'b0;
        @(posedge clk); #1;
        chk("abort_lines", {29'd0, spi_sck, spi_mosi, spi_ss_n}, 32'd3);
        chk("abort_irq", 32'(irq_n), 32'd1);
        @(negedge clk) reset = 1'b0;
        bus_read(REG_STAT, rd); chk("abort_stat", 32'(rd), 32'h00);
        bus_read(REG_DATA, rd); chk("abort_rx", 32'(rd), 32'h00);
        bus_read(REG_DIV, rd);  chk("abort_div", 32'(rd), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
